// File: rtl/frame_sync_mode_apply_if.sv
// Mode request/apply bundle between the switch-panel side and the frame-synchronous mode applier.
// dbg_state mirrors the applier FSM so checkers can observe it without hierarchical references.
interface frame_sync_mode_apply_if;
    logic [3:0]  mode_req;
    logic        vsync;
    logic [3:0]  mode_active;
    logic        mode_changed;
    logic        busy;
    logic [15:0] led;
    logic [1:0]  dbg_state;

    // mode_req/vsync are level inputs sampled every clock; there is no valid/ready handshake,
    // a request is accepted only once it has held one value for STABLE_CYCLES clocks.
    modport master (
        output mode_req, vsync,
        input  mode_active, mode_changed, busy, led, dbg_state
    );

    modport slave (
        input  mode_req, vsync,
        output mode_active, mode_changed, busy, led, dbg_state
    );
endinterface

// File: rtl/frame_sync_mode_apply.sv
// Qualifies a requested mode code for stability, sanitises illegal codes and applies the change
// only at the next frame start, with a commit pulse and active-low status LEDs.
module frame_sync_mode_apply #(
    parameter int STABLE_CYCLES = 16,
    parameter int MAX_MODE      = 5,
    parameter int VS_POL        = 1,
    parameter int BLINK_BIT     = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    frame_sync_mode_apply_if.slave  io_mode
);

    localparam int          LP_CW     = $clog2(STABLE_CYCLES + 1);
    localparam int          LP_BW     = BLINK_BIT + 1;
    localparam logic [LP_CW-1:0] LP_STABLE = LP_CW'(STABLE_CYCLES);
    localparam logic [LP_CW-1:0] LP_ONE    = LP_CW'(1);
    localparam logic [3:0]  LP_MAX    = 4'(MAX_MODE);
    localparam logic        LP_VS_ACT = (VS_POL != 0);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_QUALIFY = 2'd1,
        ST_PENDING = 2'd2,
        ST_COMMIT  = 2'd3
    } state_t;

    state_t            r_state;
    logic [LP_CW-1:0]  r_cnt;
    logic [3:0]        r_cand;
    logic [3:0]        r_mode_active;
    logic              r_mode_changed;
    logic [15:0]       r_led;
    logic [LP_BW-1:0]  r_blink;
    logic              r_vs1;
    logic              r_vs2;

    state_t            w_state_next;
    logic [LP_CW-1:0]  w_cnt_next;
    logic [3:0]        w_cand_next;
    logic [3:0]        w_active_next;
    logic [LP_BW-1:0]  w_blink_next;
    logic [15:0]       w_led_next;
    logic [3:0]        w_req_s;
    logic              w_frame_start;

    assign w_req_s       = (io_mode.mode_req > LP_MAX) ? 4'd0 : io_mode.mode_req;
    assign w_frame_start = (r_vs1 == LP_VS_ACT) && (r_vs2 != LP_VS_ACT);
    assign w_blink_next  = r_blink + LP_BW'(1);
    assign w_active_next = (r_state == ST_COMMIT) ? r_cand : r_mode_active;

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        case (r_state)
            ST_IDLE: begin
                if (w_req_s != r_mode_active) begin
                    w_cand_next  = w_req_s;
                    w_cnt_next   = LP_ONE;
                    w_state_next = ST_QUALIFY;
                end
            end
            ST_QUALIFY: begin
                if (w_req_s == r_mode_active) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (w_req_s != r_cand) begin
                    w_cand_next = w_req_s;
                    w_cnt_next  = LP_ONE;
                end else begin
                    w_cnt_next = r_cnt + LP_ONE;
                    if (w_cnt_next == LP_STABLE) begin
                        w_state_next = ST_PENDING;
                    end
                end
            end
            ST_PENDING: begin
                // A request change in the frame-start cycle outranks the commit.
                if (w_req_s == r_mode_active) begin
                    w_cnt_next   = '0;
                    w_state_next = ST_IDLE;
                end else if (w_req_s != r_cand) begin
                    w_cand_next  = w_req_s;
                    w_cnt_next   = LP_ONE;
                    w_state_next = ST_QUALIFY;
                end else if (w_frame_start) begin
                    w_state_next = ST_COMMIT;
                end
            end
            ST_COMMIT: begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // LEDs are built from next-cycle values so the registered pattern lines up with the state it shows.
    always_comb begin
        w_led_next = '1;
        if (w_active_next != 4'd0) begin
            w_led_next[w_active_next - 4'd1] = 1'b0;
        end
        if ((w_state_next == ST_PENDING) && (w_cand_next != 4'd0) && (w_cand_next != w_active_next)) begin
            w_led_next[w_cand_next - 4'd1] = ~w_blink_next[BLINK_BIT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_cand         <= '0;
            r_mode_active  <= '0;
            r_mode_changed <= 1'b0;
            r_led          <= '1;
            r_blink        <= '0;
            r_vs1          <= ~LP_VS_ACT;
            r_vs2          <= ~LP_VS_ACT;
        end else begin
            r_state        <= w_state_next;
            r_cnt          <= w_cnt_next;
            r_cand         <= w_cand_next;
            r_mode_active  <= w_active_next;
            r_mode_changed <= (r_state == ST_COMMIT);
            r_led          <= w_led_next;
            r_blink        <= w_blink_next;
            r_vs1          <= io_mode.vsync;
            r_vs2          <= r_vs1;
        end
    end

    assign io_mode.mode_active  = r_mode_active;
    assign io_mode.mode_changed = r_mode_changed;
    assign io_mode.busy         = (r_state != ST_IDLE);
    assign io_mode.led          = r_led;
    assign io_mode.dbg_state    = r_state;

endmodule

// File: tb/tb_frame_sync_mode_apply.sv
// Bench for frame_sync_mode_apply: directed scenarios plus random requests/vsync/reset,
// all outputs compared every cycle against a behavioural model of the mode-apply rules.
module tb_frame_sync_mode_apply;

  localparam int S    = 4;
  localparam int MAXM = 5;
  localparam int VSP  = 1;
  localparam int BB   = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  frame_sync_mode_apply_if bus();

  frame_sync_mode_apply #(
    .STABLE_CYCLES(S),
    .MAX_MODE(MAXM),
    .VS_POL(VSP),
    .BLINK_BIT(BB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io_mode(bus.slave)
  );

  int n_vec = 0;
  int n_err = 0;

  // model: applied mode, candidate, cycles the candidate has been held (S = qualified), commit in flight
  int   m_act;
  int   m_cand;
  int   m_run;
  int   m_blink;
  bit   m_commit;
  bit   m_chg;
  bit   m_p1;
  bit   m_p2;
  logic [3:0] exp_q[$];

  logic [3:0] cur_req;
  logic       cur_vs;

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    m_act    = 0;
    m_cand   = 0;
    m_run    = 0;
    m_blink  = 0;
    m_commit = 0;
    m_chg    = 0;
    m_p1     = (VSP == 0);
    m_p2     = (VSP == 0);
    exp_q.delete();
  endtask

  task automatic model_step(input logic [3:0] req, input logic vs);
    int r;
    bit fs;
    r  = (int'(req) > MAXM) ? 0 : int'(req);
    fs = (m_p1 == (VSP != 0)) && (m_p2 != (VSP != 0));
    m_chg = 0;
    if (m_commit) begin
      m_act    = m_cand;
      m_commit = 0;
      m_run    = 0;
      m_chg    = 1;
      exp_q.push_back(4'(m_act));
    end else if (m_run == 0) begin
      if (r != m_act) begin
        m_cand = r;
        m_run  = 1;
      end
    end else if (r == m_act) begin
      m_run = 0;
    end else if (r != m_cand) begin
      m_cand = r;
      m_run  = 1;
    end else if (m_run < S) begin
      m_run++;
    end else if (fs) begin
      m_commit = 1;
    end
    m_p2    = m_p1;
    m_p1    = vs;
    m_blink = (m_blink + 1) % (1 << (BB + 1));
  endtask

  function automatic logic [15:0] model_led();
    logic [15:0] l;
    l = '1;
    if (m_act != 0) l[m_act-1] = 1'b0;
    if (!m_commit && m_run == S && m_cand != 0 && m_cand != m_act)
      l[m_cand-1] = ~(((m_blink >> BB) & 1) != 0);
    return l;
  endfunction

  task automatic compare_outputs();
    check_eq("mode_active", 16'(bus.mode_active), 16'(m_act));
    check_eq("mode_changed", 16'(bus.mode_changed), 16'(m_chg));
    check_eq("busy", 16'(bus.busy), 16'((m_run != 0) || m_commit));
    check_eq("led", bus.led, model_led());
    if (bus.mode_changed === 1'b1) begin
      if (exp_q.size() == 0) check_eq("commit_unexpected", 16'd1, 16'd0);
      else check_eq("commit_value", 16'(bus.mode_active), 16'(exp_q.pop_front()));
    end
  endtask

  task automatic step(input logic [3:0] req, input logic vs, input logic rv);
    @(negedge clk);
    bus.mode_req = req;
    bus.vsync    = vs;
    rst          = rv;
    cur_req      = req;
    cur_vs       = vs;
    @(posedge clk);
    if (rv) model_reset();
    else model_step(req, vs);
    #1;
    compare_outputs();
  endtask

  // vsync period 12 cycles, enough for a request to qualify and commit inside n cycles
  task automatic run_frames(input logic [3:0] req, input int n);
    for (int i = 0; i < n; i++) step(req, ((i / 6) % 2) == 1, 1'b0);
  endtask

  // raise vsync and count steps until the commit pulse, bounded
  task automatic raise_and_wait(input string tag, output int k);
    step(cur_req, 1'b1, 1'b0);
    k = 1;
    while (bus.mode_changed !== 1'b1 && k < 12) begin
      step(cur_req, 1'b1, 1'b0);
      k++;
    end
    check_eq(tag, 16'(k), 16'd3);
  endtask

  initial begin
    int k;
    bit saw0, saw1;
    int vs_left;
    logic vs_r;
    logic [3:0] rq;
    logic rv;

    model_reset();
    bus.mode_req = 4'd3;
    bus.vsync    = 1'b0;
    cur_req      = 4'd3;
    cur_vs       = 1'b0;
    #1 rst = 1'b1;
    #1 compare_outputs();

    // reset held with vsync toggling and a request present
    for (int i = 0; i < 6; i++) step(4'd3, i[0], 1'b1);

    // release: request 3 qualifies and waits for a frame start
    for (int i = 0; i < 8; i++) step(4'd3, 1'b0, 1'b0);
    check_eq("s1_busy_pending", 16'(bus.busy), 16'd1);
    check_eq("s1_no_commit", 16'(bus.mode_active), 16'd0);
    raise_and_wait("s1_latency", k);
    check_eq("s1_active", 16'(bus.mode_active), 16'd3);
    check_eq("s1_led", bus.led, 16'hFFFB);

    // back to 0, then 0->2 with a long pending window to observe the blink
    run_frames(4'd0, 40);
    check_eq("s2_active0", 16'(bus.mode_active), 16'd0);
    saw0 = 0;
    saw1 = 0;
    for (int i = 0; i < 24; i++) begin
      step(4'd2, 1'b0, 1'b0);
      if (i >= 6) begin
        if (bus.led[1] === 1'b0) saw0 = 1;
        if (bus.led[1] === 1'b1) saw1 = 1;
      end
    end
    check_eq("s2_blink", 16'({saw0, saw1}), 16'b11);
    raise_and_wait("s2_latency", k);
    check_eq("s2_active", 16'(bus.mode_active), 16'd2);
    step(4'd2, 1'b1, 1'b0);
    check_eq("s2_led", bus.led, 16'hFFFD);

    // glitch to 4 for two cycles then back
    step(4'd4, 1'b0, 1'b0);
    step(4'd4, 1'b1, 1'b0);
    step(4'd2, 1'b0, 1'b0);
    check_eq("s3_busy_drop", 16'(bus.busy), 16'd0);
    run_frames(4'd2, 20);
    check_eq("s3_active", 16'(bus.mode_active), 16'd2);

    // illegal code treated as 0
    run_frames(4'd3, 40);
    check_eq("s4_active3", 16'(bus.mode_active), 16'd3);
    run_frames(4'd9, 40);
    check_eq("s4_active0", 16'(bus.mode_active), 16'd0);
    check_eq("s4_led", bus.led, 16'hFFFF);

    // request change in the exact frame-start cycle
    for (int i = 0; i < 8; i++) step(4'd5, 1'b0, 1'b0);
    step(4'd5, 1'b1, 1'b0);
    step(4'd1, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(4'd1, 1'b1, 1'b0);
    step(4'd1, 1'b0, 1'b0);
    step(4'd1, 1'b0, 1'b0);
    check_eq("s5_no_commit", 16'(bus.mode_active), 16'd0);
    raise_and_wait("s5_latency", k);
    check_eq("s5_active", 16'(bus.mode_active), 16'd1);
    step(4'd1, 1'b1, 1'b0);
    check_eq("s5_led", bus.led, 16'hFFFE);

    // reset while pending 4 with mode 2 applied
    run_frames(4'd2, 40);
    for (int i = 0; i < 8; i++) step(4'd4, 1'b0, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("s6_active", 16'(bus.mode_active), 16'd0);
    check_eq("s6_busy", 16'(bus.busy), 16'd0);
    check_eq("s6_led", bus.led, 16'hFFFF);
    check_eq("s6_changed", 16'(bus.mode_changed), 16'd0);
    model_reset();
    step(4'd4, 1'b1, 1'b1);
    step(4'd4, 1'b0, 1'b1);

    // random requests, vsync periods and occasional resets
    vs_left = 5;
    vs_r    = 1'b0;
    rq      = 4'd0;
    for (int c = 0; c < 3000; c++) begin
      if (vs_left == 0) begin
        vs_r    = ~vs_r;
        vs_left = $urandom_range(2, 25);
      end else begin
        vs_left--;
      end
      case ($urandom_range(0, 39))
        0:       rq = 4'($urandom_range(0, 15));
        1, 2:    rq = 4'($urandom_range(0, MAXM));
        default: ;
      endcase
      rv = ($urandom_range(0, 699) == 0);
      step(rq, vs_r, rv);
    end
    for (int i = 0; i < 4; i++) step(rq, vs_r, 1'b0);

    check_eq("queue_drain", 16'(exp_q.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
